// File: rtl/uart_receiver_if.sv
// UART receive-side bundle: serial line in, byte/strobe/error flags out.
// The receiver takes the slave view; the line driver / host takes master.
interface uart_receiver_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Single mid-bit sample per bit from a 2-flop synchronised line.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_SEL   = 1
) (
    input  logic clk,
    input  logic reset_n,
    uart_receiver_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam bit HAS_PAR = (PARITY_SEL != 3);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_e;

    state_e        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_bad_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          perr_q;
    logic          ferr_q;
    logic          busy_q;
    logic          rx_s;
    logic          par_exp_d;

    assign rx_s = sync_q[1];

    always_comb begin
        par_exp_d = 1'b0;
        if (PARITY_SEL == 1)
            par_exp_d = ^shift_q;
        else if (PARITY_SEL == 2)
            par_exp_d = ~^shift_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx};
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // High at mid start bit means a glitch, not a frame
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_q <= HAS_PAR ? PARITY : STOP;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q     <= '0;
                        par_bad_q <= rx_s ^ par_exp_d;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                        perr_q  <= HAS_PAR ? par_bad_q : 1'b0;
                        ferr_q  <= ~rx_s;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level model with expected delivery
// cycles, per-cycle output compare, and directed literal checks.
module tb_uart_receiver;
    localparam int N   = 16;
    localparam int LAT = 2 + N / 2 + 10 * N + 1;

    typedef struct {
        int         id;
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t       q[$];
    logic [7:0] last_d [2];
    logic       last_pe[2];
    logic       last_fe[2];
    int         vcnt[2];
    int         vcyc[2];
    int         sel[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver_if bus_a ();
    uart_receiver_if bus_b ();

    uart_receiver #(.CLKS_PER_BIT(N), .PARITY_SEL(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
    );
    uart_receiver #(.CLKS_PER_BIT(N), .PARITY_SEL(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
    );

    function automatic logic par_rule(int s, logic [7:0] d);
        if (s == 0) return 1'b0;
        if (s == 1) return ^d;
        return ~^d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic busy_of(int k);
        return (k == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    task automatic setrx(int k, logic v);
        if (k == 0) bus_a.rx = v;
        else        bus_b.rx = v;
    endtask

    // Drives one full frame starting at a negedge; optionally predicts it.
    task automatic send(input int k, input logic [7:0] d, input logic p,
                        input logic s, input bit push, output int c);
        exp_t e;
        c = cyc;
        if (push) begin
            e.id = k;
            e.t  = c + LAT;
            e.d  = d;
            e.pe = (p != par_rule(sel[k], d));
            e.fe = ~s;
            q.push_back(e);
        end
        setrx(k, 1'b0);
        repeat (N) @(negedge clk);
        chk($sformatf("dut%0d busy_in_frame", k), busy_of(k), 1);
        for (int i = 0; i < 8; i++) begin
            setrx(k, d[i]);
            repeat (N) @(negedge clk);
        end
        setrx(k, p);
        repeat (N) @(negedge clk);
        setrx(k, s);
        repeat (N) @(negedge clk);
    endtask

    logic [7:0] cd;
    logic       cv, cpe, cfe, cbz;
    int         idx;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cd  = (k == 0) ? bus_a.rx_data    : bus_b.rx_data;
            cv  = (k == 0) ? bus_a.rx_valid   : bus_b.rx_valid;
            cpe = (k == 0) ? bus_a.parity_err : bus_b.parity_err;
            cfe = (k == 0) ? bus_a.frame_err  : bus_b.frame_err;
            cbz = (k == 0) ? bus_a.busy       : bus_b.busy;
            idx = -1;
            foreach (q[j]) if (idx < 0 && q[j].id == k) idx = j;
            if (cv) begin
                vcnt[k]++;
                vcyc[k] = cyc;
                chk($sformatf("dut%0d valid_expected", k), idx >= 0, 1);
                if (idx >= 0) begin
                    chk($sformatf("dut%0d valid_cycle", k), cyc, q[idx].t);
                    chk($sformatf("dut%0d data", k), cd, q[idx].d);
                    chk($sformatf("dut%0d parity_err", k), cpe, q[idx].pe);
                    chk($sformatf("dut%0d frame_err", k), cfe, q[idx].fe);
                    chk($sformatf("dut%0d busy_at_valid", k), cbz, q[idx].fe);
                    last_d[k]  = q[idx].d;
                    last_pe[k] = q[idx].pe;
                    last_fe[k] = q[idx].fe;
                    q.delete(idx);
                end
            end else begin
                if (idx >= 0 && q[idx].t <= cyc) begin
                    chk($sformatf("dut%0d valid_missing", k), cv, 1);
                    q.delete(idx);
                end
                chk($sformatf("dut%0d hold_data", k), cd, last_d[k]);
                chk($sformatf("dut%0d hold_perr", k), cpe, last_pe[k]);
                chk($sformatf("dut%0d hold_ferr", k), cfe, last_fe[k]);
            end
        end
    end

    initial begin
        int c, c2, v0;
        sel[0] = 1;
        sel[1] = 2;
        for (int k = 0; k < 2; k++) begin
            last_d[k] = 8'h00; last_pe[k] = 1'b0; last_fe[k] = 1'b0;
            vcnt[k] = 0; vcyc[k] = 0;
        end
        bus_a.rx = 1'b1;
        bus_b.rx = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rx_data", bus_a.rx_data, 8'h00);
        chk("reset rx_valid", bus_a.rx_valid, 0);
        chk("reset busy", bus_a.busy, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // nominal frame
        v0 = vcnt[0];
        send(0, 8'hA5, 1'b0, 1'b1, 1, c);
        chk("nominal latency", vcyc[0] - c, 171);
        chk("nominal count", vcnt[0] - v0, 1);
        chk("nominal data", bus_a.rx_data, 8'hA5);
        chk("nominal perr", bus_a.parity_err, 0);
        chk("nominal ferr", bus_a.frame_err, 0);
        chk("nominal busy idle", bus_a.busy, 0);

        // parity error, then cleared by a good frame
        send(0, 8'hA5, 1'b1, 1'b1, 1, c);
        chk("perr data", bus_a.rx_data, 8'hA5);
        chk("perr flag", bus_a.parity_err, 1);
        chk("perr ferr", bus_a.frame_err, 0);
        send(0, 8'h3C, 1'b0, 1'b1, 1, c);
        chk("perr clear data", bus_a.rx_data, 8'h3C);
        chk("perr clear flag", bus_a.parity_err, 0);

        // false start
        v0 = vcnt[0];
        bus_a.rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch busy", bus_a.busy, 1);
        bus_a.rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        chk("glitch idle", bus_a.busy, 0);
        chk("glitch no valid", vcnt[0] - v0, 0);
        chk("glitch data kept", bus_a.rx_data, 8'h3C);
        send(0, 8'h01, 1'b1, 1'b1, 1, c);
        chk("after glitch data", bus_a.rx_data, 8'h01);
        chk("after glitch perr", bus_a.parity_err, 0);

        // framing error followed by a long break
        v0 = vcnt[0];
        send(0, 8'h55, 1'b0, 1'b0, 1, c);
        repeat (20 * N) @(negedge clk);
        chk("break busy mid", bus_a.busy, 1);
        repeat (20 * N) @(negedge clk);
        chk("break count", vcnt[0] - v0, 1);
        chk("break data", bus_a.rx_data, 8'h55);
        chk("break ferr", bus_a.frame_err, 1);
        chk("break busy end", bus_a.busy, 1);
        bus_a.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("break released", bus_a.busy, 0);
        repeat (N) @(negedge clk);
        send(0, 8'hFF, 1'b0, 1'b1, 1, c);
        chk("post break data", bus_a.rx_data, 8'hFF);
        chk("post break ferr", bus_a.frame_err, 0);

        // back-to-back on the odd-parity receiver
        v0 = vcnt[1];
        send(1, 8'h00, 1'b1, 1'b1, 1, c);
        send(1, 8'hFF, 1'b1, 1'b1, 1, c);
        send(1, 8'h81, 1'b1, 1'b1, 1, c2);
        repeat (4) @(negedge clk);
        chk("b2b count", vcnt[1] - v0, 3);
        chk("b2b last latency", vcyc[1] - c2, 171);
        chk("b2b last data", bus_b.rx_data, 8'h81);
        chk("b2b last perr", bus_b.parity_err, 0);

        // reset during data bit 4
        v0 = vcnt[0];
        bus_a.rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_a.rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (N) @(negedge clk);
        end
        repeat (N / 2) @(negedge clk);
        #2 reset_n = 1'b0;
        q.delete();
        for (int k = 0; k < 2; k++) begin
            last_d[k] = 8'h00; last_pe[k] = 1'b0; last_fe[k] = 1'b0;
        end
        #1;
        chk("rst mid data", bus_a.rx_data, 8'h00);
        chk("rst mid valid", bus_a.rx_valid, 0);
        chk("rst mid busy", bus_a.busy, 0);
        chk("rst mid b data", bus_b.rx_data, 8'h00);
        @(negedge clk);
        bus_a.rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (N) @(negedge clk);
        chk("rst mid no valid", vcnt[0] - v0, 0);
        send(0, 8'h5A, 1'b0, 1'b1, 1, c);
        chk("post rst data", bus_a.rx_data, 8'h5A);
        chk("post rst perr", bus_a.parity_err, 0);

        repeat (10) @(negedge clk);
        chk("model drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
